uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, one TX bit period per cycle; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port P_DATA, input, DATA_WIDTH bits: parallel payload, sampled only on acceptance.
REQ-005 SHALL have port Data_Valid, input, 1 bit: request to send P_DATA.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 means a parity bit is inserted, sampled on acceptance.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 means even parity, 1 means odd parity, sampled on acceptance.
REQ-008 SHALL have port TX_OUT, output, 1 bit: registered serial line, idle high.
REQ-009 SHALL have port Busy, output, 1 bit: registered, high while a frame is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-011 SHALL accept a request only when state is IDLE and Data_Valid=1 at a rising edge (edge k); Data_Valid in any other state SHALL be ignored with no queuing.
REQ-012 On acceptance at edge k, SHALL latch P_DATA, PAR_EN and PAR_TYP into internal registers; later changes on those inputs SHALL NOT affect the frame.
REQ-013 After edge k, SHALL drive TX_OUT=0 (start bit) for exactly one cycle, with Busy=1.
REQ-014 After edges k+1 to k+DATA_WIDTH, SHALL drive the latched data LSB first, one bit per cycle; the bit counter SHALL be ceil(log2(DATA_WIDTH)) bits wide and SHALL NOT wrap within a frame.
REQ-015 If latched PAR_EN=1, after edge k+DATA_WIDTH+1 SHALL drive the parity bit for one cycle: ^data when PAR_TYP=0, ~^data when PAR_TYP=1.
REQ-016 Next SHALL drive the stop bit TX_OUT=1 for one cycle, still with Busy=1.
REQ-017 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 cycles without.
REQ-018 At the edge ending STOP, SHALL enter IDLE with Busy=0 and TX_OUT=1.
REQ-019 With Data_Valid held high, SHALL insert exactly one idle cycle (TX_OUT=1, Busy=0) between frames.
REQ-020 SHALL update Busy and TX_OUT on the same edge as the state transition, with no combinational path from inputs to outputs.
REQ-021 Transition rules:
  IDLE to START on acceptance.
  START to DATA unconditionally.
  DATA to PARITY or STOP after the last data bit, per latched PAR_EN.
  PARITY to STOP.
  STOP to IDLE.

Reset
REQ-022 When RST=0, SHALL immediately (asynchronously) force state IDLE, TX_OUT=1, Busy=0, bit counter 0 and latched registers 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further frame bits driven.
REQ-024 After RST deasserts, the first acceptance SHALL occur no earlier than the first rising edge with RST=1 and Data_Valid=1.

Verification
REQ-025 Even-parity frame: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (start, data, parity=0, stop); Busy high for 11 cycles, then low.
REQ-026 Odd parity and no-parity frames, P_DATA=0xA5: PAR_TYP=1 -> parity bit 1; PAR_EN=0 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1.
REQ-027 Latching: P_DATA=0x01 accepted, then P_DATA=0xFF and PAR_TYP toggled mid-frame, and Data_Valid pulsed while Busy=1 -> frame still carries 0x01 with its accepted parity setting; no second frame starts.
REQ-028 Back-to-back: Data_Valid held high with 0x3C then 0xC3 -> two complete frames separated by exactly one idle cycle with TX_OUT=1 and Busy=0.
REQ-029 Reset mid-frame: RST driven low during data bit 3 -> TX_OUT=1 and Busy=0 without waiting for a clock edge; a new 0x5A request after release produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: one-bit-per-clock UART transmitter (in: CLK, RST async low, P_DATA, Data_Valid, PAR_EN, PAR_TYP; out: TX_OUT idle-high serial line, Busy)
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] data_r;
  logic [CW-1:0]         cnt;
  logic                  par_en_r;
  logic                  par_bit_r;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state     <= IDLE;
      data_r    <= '0;
      cnt       <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Data_Valid) begin
          state     <= START;
          data_r    <= P_DATA;
          par_en_r  <= PAR_EN;
          par_bit_r <= ^P_DATA ^ PAR_TYP;
          cnt       <= '0;
          TX_OUT    <= 1'b0;
          Busy      <= 1'b1;
        end
        START: begin
          state  <= DATA;
          TX_OUT <= data_r[0];
        end
        DATA: if (cnt == LAST) begin
          state  <= par_en_r ? PARITY : STOP;
          TX_OUT <= par_en_r ? par_bit_r : 1'b1;
        end else begin
          cnt    <= cnt + 1'b1;
          TX_OUT <= data_r[cnt + 1'b1];
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: randomized and directed self-checking bench for uart_tx_core against a frame-level model
module tb_uart_tx_core;
  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;
  int         checks = 0;
  int         failures = 0;
  bit         exp_q[$];

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic build_frame(input logic [7:0] d, input bit pe, input bit pt);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    Data_Valid = 1'b1;
    P_DATA = 8'($urandom);
    repeat (3) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    end
    Data_Valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_directed(input logic [7:0] d, input bit pe, input bit pt, input string name);
    build_frame(d, pe, pt);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        failures++;
        $display("FAIL %s bit=%0d tx=%b busy=%b expected tx=%b busy=1", name, i, TX_OUT, Busy, exp_q[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end tx=%b busy=%b expected tx=1 busy=0", name, TX_OUT, Busy);
    end
  endtask

  task automatic test_latching();
    build_frame(8'h01, 1'b1, 1'b0);
    @(negedge CLK);
    P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0; P_DATA = 8'hFF; PAR_TYP = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      Data_Valid = (i == 3);
      checks++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        failures++;
        $display("FAIL latching bit=%0d tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, Busy, exp_q[i]);
      end
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL latching_no_second cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    build_frame(8'h3C, 1'b1, 1'b0);
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hC3; PAR_TYP = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_first bit=%0d tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, Busy, exp_q[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    end
    build_frame(8'hC3, 1'b1, 1'b1);
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_second bit=%0d tx=%b busy=%b expected tx=%b busy=1", i, TX_OUT, Busy, exp_q[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_reset_midframe();
    build_frame(8'h5A, 1'b0, 1'b0);
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge CLK);
    checks++;
    if (TX_OUT !== exp_q[4] || Busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre tx=%b busy=%b expected tx=%b busy=1", TX_OUT, Busy, exp_q[4]);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL midreset_abort cyc=%0d tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
      end
    end
    test_directed(8'h5A, 1'b1, 1'b0, "midreset_new_frame");
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         pe;
    bit         pt;
    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      test_directed(d, pe, pt, "random");
    end
  endtask

  initial begin
    RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    test_reset();
    test_directed(8'hA5, 1'b1, 1'b0, "even_parity");
    test_directed(8'hA5, 1'b1, 1'b1, "odd_parity");
    test_directed(8'hA5, 1'b0, 1'b0, "no_parity");
    test_latching();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
